// File: rtl/i2c_wb_multi.sv
// Wishbone-fed I2C write sequencer: per-channel command FIFO feeding the host side of an i2c_master.
// Optional feature macro I2C_READBACK_EN adds queued single-byte register reads and Wishbone readback.
module i2c_wb_multi #(
    parameter int unsigned              NUM_CH        = 2,
    parameter int unsigned              DEPTH         = 4,
    parameter int unsigned              WB_ADDR_WIDTH = 6,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADR      = 6'h3d,
    parameter logic [7:0]               OP_WRITE      = 8'h06
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WB_ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic                     wbs_we_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_CH*7-1:0]      cmd_address,
    output logic [NUM_CH-1:0]        cmd_start,
    output logic [NUM_CH-1:0]        cmd_read,
    output logic [NUM_CH-1:0]        cmd_write,
    output logic [NUM_CH-1:0]        cmd_write_multiple,
    output logic [NUM_CH-1:0]        cmd_stop,
    output logic [NUM_CH-1:0]        cmd_valid,
    input  logic [NUM_CH-1:0]        cmd_ready,
    output logic [NUM_CH*8-1:0]      data_out,
    output logic [NUM_CH-1:0]        data_out_valid,
    output logic [NUM_CH-1:0]        data_out_last,
    input  logic [NUM_CH-1:0]        data_out_ready,
    input  logic [NUM_CH*8-1:0]      data_in,
    input  logic [NUM_CH-1:0]        data_in_valid,
    input  logic [NUM_CH-1:0]        missed_ack,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        nack_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_REG   = 3'd2;
    localparam logic [2:0] S_VAL   = 3'd3;
`ifdef I2C_READBACK_EN
    localparam logic [2:0] S_RCMD  = 3'd4;
    localparam logic [2:0] S_RWAIT = 3'd5;
    localparam logic [7:0] OP_READ = 8'h07;
`endif

    logic              ack_q;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] push;
    logic              wr_req;
    logic              entry_rd;
    logic              op_ok;
    logic [23:0]       entry;
    logic              rd_acc;
    logic              unused_inputs;

    // ack_q blocks a new accept so ack can never be high two cycles in a row
    assign wr_req = wbs_cyc_i & wbs_stb_i & wbs_we_i & ~ack_q;
`ifdef I2C_READBACK_EN
    assign entry_rd = (wbs_dat_i[31:24] == OP_READ);
`else
    assign entry_rd = 1'b0;
`endif
    assign op_ok = (wbs_dat_i[31:24] == OP_WRITE) | entry_rd;
    // bit 23 of a queued entry marks a read; the bus never carries a meaningful bit 23
    assign entry = {entry_rd, wbs_dat_i[22:0]};

`ifdef I2C_READBACK_EN
    logic [NUM_CH*8-1:0] rdreg_all;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [23:0]   mem_q [DEPTH];
        logic [AW-1:0] wp_q;
        logic [AW-1:0] rp_q;
        logic [AW:0]   cnt_q;
        logic [AW:0]   cnt_d;
        logic [2:0]    st_q;
        logic [2:0]    st_d;
        logic [23:0]   cur_q;
        logic [23:0]   cur_d;
        logic          nack_q;
        logic          pop;
        logic          full;
        logic          is_rd;

        assign sel[c]  = ({1'b0, wbs_adr_i} == ({1'b0, BASE_ADR} + (WB_ADDR_WIDTH+1)'(c)));
        assign full    = (cnt_q == (AW+1)'(DEPTH));
        assign push[c] = wr_req & sel[c] & op_ok & ~full;
        assign pop     = (st_q == S_IDLE) && (cnt_q != '0);
        assign cnt_d   = cnt_q + (AW+1)'(push[c]) - (AW+1)'(pop);
        assign is_rd   = cur_q[23];

        always_comb begin
            st_d  = st_q;
            cur_d = cur_q;
            case (st_q)
                S_IDLE: if (pop) begin
                    cur_d = mem_q[rp_q];
                    st_d  = S_CMD;
                end
                S_CMD:  if (cmd_ready[c]) st_d = S_REG;
`ifdef I2C_READBACK_EN
                S_REG:  if (data_out_ready[c]) st_d = is_rd ? S_RCMD : S_VAL;
                S_RCMD: if (cmd_ready[c]) st_d = S_RWAIT;
                S_RWAIT: if (data_in_valid[c]) st_d = S_IDLE;
`else
                S_REG:  if (data_out_ready[c]) st_d = S_VAL;
`endif
                S_VAL:  if (data_out_ready[c]) st_d = S_IDLE;
                default: st_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (push[c]) mem_q[wp_q] <= entry;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wp_q   <= '0;
                rp_q   <= '0;
                cnt_q  <= '0;
                st_q   <= S_IDLE;
                cur_q  <= '0;
                nack_q <= 1'b0;
            end else begin
                if (push[c]) wp_q <= wp_q + 1'b1;
                if (pop)     rp_q <= rp_q + 1'b1;
                cnt_q <= cnt_d;
                st_q  <= st_d;
                cur_q <= cur_d;
                if (missed_ack[c]) nack_q <= 1'b1;
            end
        end

`ifdef I2C_READBACK_EN
        logic [7:0] rdreg_q;
        always_ff @(posedge clk) begin
            if (rst) rdreg_q <= '0;
            else if (st_q == S_RWAIT && data_in_valid[c]) rdreg_q <= data_in[8*c +: 8];
        end
        assign rdreg_all[8*c +: 8] = rdreg_q;
        assign cmd_valid[c] = (st_q == S_CMD) | (st_q == S_RCMD);
        assign cmd_read[c]  = (st_q == S_RCMD);
        assign cmd_stop[c]  = ((st_q == S_CMD) & ~is_rd) | (st_q == S_RCMD);
`else
        assign cmd_valid[c] = (st_q == S_CMD);
        assign cmd_read[c]  = 1'b0;
        assign cmd_stop[c]  = (st_q == S_CMD) & ~is_rd;
`endif
        assign cmd_start[c]          = cmd_valid[c];
        assign cmd_write[c]          = (st_q == S_CMD) & is_rd;
        assign cmd_write_multiple[c] = (st_q == S_CMD) & ~is_rd;
        assign cmd_address[7*c +: 7] = cur_q[22:16];
        assign data_out_valid[c]     = (st_q == S_REG) | (st_q == S_VAL);
        assign data_out_last[c]      = (st_q == S_VAL) | ((st_q == S_REG) & is_rd);
        assign data_out[8*c +: 8]    = (st_q == S_REG) ? cur_q[15:8] : cur_q[7:0];
        assign busy[c]               = (cnt_q != '0) | (st_q != S_IDLE);
        assign nack_err[c]           = nack_q;
    end

`ifdef I2C_READBACK_EN
    logic [31:0] rd_dat;
    logic [31:0] dat_o_q;
    always_comb begin
        rd_acc = 1'b0;
        rd_dat = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sel[c]) begin
                rd_acc = wbs_cyc_i & wbs_stb_i & ~wbs_we_i & ~ack_q;
                rd_dat = {busy[c], nack_err[c], 22'b0, rdreg_all[8*c +: 8]};
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) dat_o_q <= '0;
        else     dat_o_q <= rd_dat;
    end
    assign wbs_dat_o     = dat_o_q;
    assign unused_inputs = wbs_dat_i[23];
`else
    assign rd_acc        = 1'b0;
    assign wbs_dat_o     = '0;
    assign unused_inputs = ^{wbs_dat_i[23], data_in, data_in_valid};
`endif

    always_ff @(posedge clk) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= (|push) | rd_acc;
    end
    assign wbs_ack_o = ack_q;
endmodule

// File: tb/tb_i2c_wb_multi.sv
// Self-checking bench for i2c_wb_multi: vector table for Wishbone decode plus scoreboarded I2C host traffic.
module tb_i2c_wb_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_we_i, wbs_stb_i, wbs_cyc_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [13:0] cmd_address;
    logic [1:0]  cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
    logic [1:0]  cmd_ready;
    logic [15:0] data_out;
    logic [1:0]  data_out_valid, data_out_last, data_out_ready;
    logic [15:0] data_in;
    logic [1:0]  data_in_valid, missed_ack;
    logic [1:0]  busy, nack_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_wb_multi #(.NUM_CH(2), .DEPTH(4), .WB_ADDR_WIDTH(6), .BASE_ADR(6'h3d), .OP_WRITE(8'h06)) dut (
        .clk(clk), .rst(rst),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_we_i(wbs_we_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_write(cmd_write),
        .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_last(data_out_last), .data_out_ready(data_out_ready), .data_in(data_in),
        .data_in_valid(data_in_valid), .missed_ack(missed_ack), .busy(busy), .nack_err(nack_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard entries are {is_read, dev[6:0], reg[7:0], val[7:0]} per channel
    logic [23:0] q0[$];
    logic [23:0] q1[$];

    function automatic void sb_push(input int c, input logic [23:0] e);
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic logic [24:0] sb_pop(input int c);
        if (c == 0) begin
            if (q0.size() == 0) return '0;
            return {1'b1, q0.pop_front()};
        end
        if (q1.size() == 0) return '0;
        return {1'b1, q1.pop_front()};
    endfunction

    int          ph  [2];
    logic [23:0] cur [2];

    always @(negedge clk) begin
        logic [24:0] e;
        if (rst) begin
            ph[0] = 0;
            ph[1] = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (cmd_valid[c] && cmd_ready[c]) begin
                    if (ph[c] == 3) begin
                        chk($sformatf("ch%0d_rcmd_flags", c),
                            {cmd_start[c], cmd_read[c], cmd_write[c], cmd_write_multiple[c], cmd_stop[c]}, 5'b11001);
                        chk($sformatf("ch%0d_rcmd_addr", c), cmd_address[7*c +: 7], cur[c][22:16]);
                        ph[c] = 4;
                    end else begin
                        e = sb_pop(c);
                        chk($sformatf("ch%0d_cmd_expected", c), e[24], 1);
                        cur[c] = e[23:0];
                        chk($sformatf("ch%0d_cmd_flags", c),
                            {cmd_start[c], cmd_read[c], cmd_write[c], cmd_write_multiple[c], cmd_stop[c]},
                            cur[c][23] ? 5'b10100 : 5'b10011);
                        chk($sformatf("ch%0d_cmd_addr", c), cmd_address[7*c +: 7], cur[c][22:16]);
                        ph[c] = 1;
                    end
                end
                if (data_out_valid[c] && data_out_ready[c]) begin
                    if (ph[c] == 1) begin
                        chk($sformatf("ch%0d_reg_byte", c), {data_out_last[c], data_out[8*c +: 8]},
                            {cur[c][23], cur[c][15:8]});
                        ph[c] = cur[c][23] ? 3 : 2;
                    end else if (ph[c] == 2) begin
                        chk($sformatf("ch%0d_val_byte", c), {data_out_last[c], data_out[8*c +: 8]},
                            {1'b1, cur[c][7:0]});
                        ph[c] = 0;
                    end else begin
                        chk($sformatf("ch%0d_byte_phase", c), ph[c], 1);
                    end
                end
                if (ph[c] == 4 && data_in_valid[c]) ph[c] = 0;
            end
        end
    end

    // waited counts sampled cycles without ack before the ack cycle (1 = ack on the cycle after the request)
    task automatic wb_xfer(input logic [5:0] a, input logic [31:0] d, input logic w, input int maxw,
                           output logic acked, output int waited, output logic [31:0] rdat);
        @(posedge clk); #1;
        wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = w; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        acked = 1'b0; waited = 0; rdat = '0;
        while (!acked && waited < maxw) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
            end else begin
                waited++;
            end
        end
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (acked) begin
            @(negedge clk);
            chk("ack_one_cycle", wbs_ack_o, 0);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy !== 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, busy, 2'b00);
    endtask

    typedef struct packed {
        logic [5:0]  adr;
        logic [31:0] dat;
        logic        we;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acked;
        int          waited;
        logic [31:0] rdat;
        vec_t        v;

        rst = 1'b1;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_we_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        cmd_ready = 2'b11; data_out_ready = 2'b11; data_in = '0; data_in_valid = '0; missed_ack = '0;

        vecs.push_back('{adr: 6'h3d, dat: 32'h066A1234, we: 1'b1, exp_ack: 1'b1});
        vecs.push_back('{adr: 6'h3e, dat: 32'h06501199, we: 1'b1, exp_ack: 1'b1});
        vecs.push_back('{adr: 6'h3d, dat: 32'h056A1234, we: 1'b1, exp_ack: 1'b0});
        vecs.push_back('{adr: 6'h3c, dat: 32'h066A1234, we: 1'b1, exp_ack: 1'b0});
        vecs.push_back('{adr: 6'h3f, dat: 32'h06112233, we: 1'b1, exp_ack: 1'b0});
        vecs.push_back('{adr: 6'h3e, dat: 32'h067FFF00, we: 1'b1, exp_ack: 1'b1});
        vecs.push_back('{adr: 6'h3d, dat: 32'h06801122, we: 1'b1, exp_ack: 1'b1});
`ifndef I2C_READBACK_EN
        vecs.push_back('{adr: 6'h3d, dat: 32'h07501100, we: 1'b1, exp_ack: 1'b0});
        vecs.push_back('{adr: 6'h3d, dat: 32'h00000000, we: 1'b0, exp_ack: 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ack_dat", {31'b0, wbs_ack_o} | wbs_dat_o, 0);
        chk("reset_valids", {cmd_valid, data_out_valid, data_out_last}, 0);
        chk("reset_cmd_flags", {cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop}, 0);
        chk("reset_payload", {cmd_address, data_out}, 0);
        chk("reset_busy_nack", {busy, nack_err}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.exp_ack) sb_push((v.adr == 6'h3e) ? 1 : 0, {1'b0, v.dat[22:0]});
            wb_xfer(v.adr, v.dat, v.we, 4, acked, waited, rdat);
            chk($sformatf("vec%0d_ack", i), acked, v.exp_ack);
            if (acked) chk($sformatf("vec%0d_ack_latency", i), waited, 1);
        end
        wait_idle("table_drain_busy");
        chk("table_sb_empty", q0.size() + q1.size(), 0);

        // FIFO full: one command held in the FSM plus DEPTH queued, the next write stalls
        cmd_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            sb_push(0, {1'b0, 7'h20 + 7'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)});
            wb_xfer(6'h3d, {8'h06, 1'b0, 7'h20 + 7'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)}, 1'b1, 4, acked, waited, rdat);
            chk($sformatf("fill%0d_ack", i), acked, 1);
        end
        sb_push(0, 24'h2545AA);
        fork
            begin
                repeat (6) @(posedge clk);
                #1 cmd_ready = 2'b11;
            end
        join_none
        wb_xfer(6'h3d, 32'h062545AA, 1'b1, 40, acked, waited, rdat);
        chk("stall_acked", acked, 1);
        chk("stall_waited", waited > 5, 1);
        wait_idle("stall_drain_busy");
        chk("stall_sb_empty", q0.size(), 0);

        // both channels hold a command at once, then drain concurrently
        cmd_ready = 2'b00;
        sb_push(0, 24'h0A0102);
        wb_xfer(6'h3d, 32'h060A0102, 1'b1, 4, acked, waited, rdat);
        sb_push(1, 24'h0B0304);
        wb_xfer(6'h3e, 32'h060B0304, 1'b1, 4, acked, waited, rdat);
        chk("concurrent_busy", busy, 2'b11);
        chk("concurrent_cmd_valid", cmd_valid, 2'b11);
        cmd_ready = 2'b11;
        wait_idle("concurrent_drain_busy");
        chk("concurrent_sb_empty", q0.size() + q1.size(), 0);

        @(posedge clk); #1 missed_ack = 2'b10;
        @(posedge clk); #1 missed_ack = 2'b00;
        @(negedge clk);
        chk("nack_set", nack_err, 2'b10);
        repeat (5) @(negedge clk);
        chk("nack_held", nack_err, 2'b10);

        // reset while ch0 is presenting its register byte, with two more entries queued
        cmd_ready = 2'b01; data_out_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            sb_push(0, {1'b0, 7'h30 + 7'(i), 8'h11, 8'h22});
            wb_xfer(6'h3d, {8'h06, 1'b0, 7'h30 + 7'(i), 8'h11, 8'h22}, 1'b1, 4, acked, waited, rdat);
        end
        begin
            int n = 0;
            while (!data_out_valid[0] && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_reached_reg", {data_out_valid[0], data_out[7:0], data_out_last[0]}, {1'b1, 8'h11, 1'b0});
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("rst_mid_valids", {cmd_valid, data_out_valid}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_nack_cleared", nack_err, 0);
        cmd_ready = 2'b11; data_out_ready = 2'b11;
        repeat (8) @(negedge clk);
        chk("rst_queue_discarded", {busy, cmd_valid}, 0);

`ifdef I2C_READBACK_EN
        sb_push(0, 24'hD01100);
        wb_xfer(6'h3d, 32'h07501100, 1'b1, 4, acked, waited, rdat);
        chk("rb_write_ack", acked, 1);
        begin
            int n = 0;
            while (!(cmd_valid[0] && cmd_read[0]) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rb_rcmd_seen", {cmd_valid[0], cmd_read[0]}, 2'b11);
        @(posedge clk); #1 data_in = 16'h00A5; data_in_valid = 2'b01;
        @(posedge clk); #1 data_in = '0; data_in_valid = 2'b00;
        wait_idle("rb_idle");
        wb_xfer(6'h3d, 32'h0, 1'b0, 4, acked, waited, rdat);
        chk("rb_read_ack", acked, 1);
        chk("rb_read_data", rdat, 32'h000000A5);
`endif

        wait_idle("final_busy");
        chk("final_sb_empty", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
